inst_fetch_ctrl: RTL and testbench

Upstream stage of `top`: holds a small program memory and a program counter, and sequences each instruction through a fixed four-cycle FETCH/DECODE/EXEC/WB frame. It drives the `instruction` word consumed by the datapath, plus per-phase enables for the register file and ALU. It replaces hand-timed testbench instruction driving with a self-timed issue engine. The fixed cadence is one instruction every 4 cycles.

---
 rtl/inst_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: self-timed instruction issue engine.
//
// Holds a 2**AddrSize-entry program memory and a program counter, and issues
// one instruction every four cycles through FETCH/DECODE/EXEC/WB phases.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   load_en          write load_data to mem[load_addr] (honoured only when idle)
//   load_addr        program memory write address
//   load_data        instruction word to store
//   start            begin a run at pc=0 (honoured only when idle)
//   prog_len         instructions to run (0..2**AddrSize), sampled with start
//   instruction      instruction register (IR) to the datapath
//   pc               address of the current instruction
//   enable_fetch     high in FETCH
//   enable_execute   high in EXEC
//   enable_writeback high in WB
//   busy             high whenever not idle
//   done             one-cycle pulse after a run completes
//
// Build option: define IFU_NOP_FILL_EN to load NOP into IR when a run ends;
// otherwise IR keeps the last fetched word while idle.

module inst_fetch_ctrl #(
  parameter int unsigned DataSize = 32,
  parameter int unsigned AddrSize = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_en,
  input  logic [AddrSize-1:0] load_addr,
  input  logic [DataSize-1:0] load_data,
  input  logic                start,
  input  logic [AddrSize:0]   prog_len,
  output logic [DataSize-1:0] instruction,
  output logic [AddrSize-1:0] pc,
  output logic                enable_fetch,
  output logic                enable_execute,
  output logic                enable_writeback,
  output logic                busy,
  output logic                done
);

  localparam int unsigned Depth = 1 << AddrSize;
  localparam logic [DataSize-1:0] Nop = DataSize'(32'h40000009);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StWb} state_e;

  state_e                state_q, state_d;
  logic [AddrSize-1:0]   pc_q, pc_d;
  logic [AddrSize:0]     len_q, len_d;
  logic [DataSize-1:0]   ir_q, ir_d;
  logic                  done_q, done_d;
  logic [DataSize-1:0]   mem_q [Depth];
  logic                  last_instr;

  // Compare in AddrSize+1 bits so a full-depth run ends at pc=Depth-1
  // instead of wrapping back to 0.
  assign last_instr = ({1'b0, pc_q} + (AddrSize + 1)'(1)) == len_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    ir_d    = ir_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (prog_len != '0) begin
            state_d = StFetch;
            pc_d    = '0;
            len_d   = prog_len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StFetch: begin
        ir_d    = mem_q[pc_q];
        state_d = StDecode;
      end
      StDecode: state_d = StExec;
      StExec:   state_d = StWb;
      StWb: begin
        if (last_instr) begin
          state_d = StIdle;
          done_d  = 1'b1;
          pc_d    = '0;
`ifdef IFU_NOP_FILL_EN
          ir_d    = Nop;
`else
          ir_d    = ir_q;
`endif
        end else begin
          pc_d    = pc_q + AddrSize'(1);
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      len_q   <= '0;
      ir_q    <= Nop;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
      done_q  <= done_d;
    end
  end

  // Program memory is deliberately not reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en && (state_q == StIdle)) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign instruction      = ir_q;
  assign pc               = pc_q;
  assign enable_fetch     = (state_q == StFetch);
  assign enable_execute   = (state_q == StExec);
  assign enable_writeback = (state_q == StWb);
  assign busy             = (state_q != StIdle);
  assign done             = done_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

  localparam logic [31:0] Nop  = 32'h40000009;
  localparam logic [31:0] Movi = 32'h440000C8;
  localparam logic [31:0] Addi = 32'h50200064;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic [4:0]  prog_len = '0;
  logic [31:0] instruction;
  logic [3:0]  pc;
  logic        enable_fetch, enable_execute, enable_writeback, busy, done;

  int checks = 0;
  int errors = 0;
  logic [31:0] basic_prog [3] = '{Movi, Addi, Nop};

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.DataSize(32), .AddrSize(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .load_en          (load_en),
    .load_addr        (load_addr),
    .load_data        (load_data),
    .start            (start),
    .prog_len         (prog_len),
    .instruction      (instruction),
    .pc               (pc),
    .enable_fetch     (enable_fetch),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .busy             (busy),
    .done             (done)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [3:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  // Returns just after the edge that samples start (E0).
  task automatic pulse_start(input logic [4:0] n);
    start = 1'b1; prog_len = n;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] ctl;
    #3 reset = 1'b0;
    #2;
    ctl = {enable_fetch, enable_execute, enable_writeback, busy, done};
    checks++;
    if (instruction !== Nop) begin
      errors++; $display("FAIL reset_ir: got %h want %h", instruction, Nop);
    end
    checks++;
    if (pc !== 4'd0) begin
      errors++; $display("FAIL reset_pc: got %0d want 0", pc);
    end
    checks++;
    if (ctl !== 5'b0) begin
      errors++; $display("FAIL reset_ctl: got %b want 00000", ctl);
    end
    step(); step();
    reset = 1'b1;
    step();
    ctl = {enable_fetch, enable_execute, enable_writeback, busy, done};
    checks++;
    if (ctl !== 5'b0 || instruction !== Nop) begin
      errors++; $display("FAIL post_reset: ctl %b ir %h want 00000 %h", ctl, instruction, Nop);
    end
    write_mem(4'd0, 32'h12345678);
    pulse_start(5'd1);
    step();
    checks++;
    if (instruction !== 32'h12345678) begin
      errors++; $display("FAIL reset_memwrite: got %h want 12345678", instruction);
    end
    step(); step(); step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_run1_done: done %b busy %b want 1 0", done, busy);
    end
    step();
  endtask

  task automatic test_basic();
    logic [4:0] ctl, exp_ctl;
    for (int i = 0; i < 3; i++) write_mem(4'(i), basic_prog[i]);
    pulse_start(5'd3);
    for (int c = 0; c < 12; c++) begin
      ctl = {enable_fetch, enable_execute, enable_writeback, busy, done};
      exp_ctl = {(c % 4) == 0, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_ctl[3] = (c % 4) == 2;
      exp_ctl[2] = (c % 4) == 3;
      checks++;
      if (ctl !== exp_ctl) begin
        errors++; $display("FAIL basic_ctl c=%0d: got %b want %b", c, ctl, exp_ctl);
      end
      checks++;
      if (pc !== 4'(c / 4)) begin
        errors++; $display("FAIL basic_pc c=%0d: got %0d want %0d", c, pc, c / 4);
      end
      if (c >= 1) begin
        checks++;
        if (instruction !== basic_prog[(c - 1) / 4]) begin
          errors++;
          $display("FAIL basic_ir c=%0d: got %h want %h", c, instruction, basic_prog[(c - 1) / 4]);
        end
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pc !== 4'd0) begin
      errors++; $display("FAIL basic_done: done %b busy %b pc %0d want 1 0 0", done, busy, pc);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_zero_len();
    pulse_start(5'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done: done %b busy %b want 1 0", done, busy);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL zero_idle c=%0d: done %b busy %b want 0 0", c, done, busy);
      end
    end
  endtask

  task automatic test_busy_ignore();
    pulse_start(5'd3);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL ign_busy c=%0d: busy %b done %b want 1 0", c, busy, done);
      end
      if (c >= 1) begin
        checks++;
        if (instruction !== basic_prog[(c - 1) / 4]) begin
          errors++;
          $display("FAIL ign_ir c=%0d: got %h want %h", c, instruction, basic_prog[(c - 1) / 4]);
        end
      end
      if (c == 2) begin
        checks++;
        if (enable_execute !== 1'b1) begin
          errors++; $display("FAIL ign_exec: got %b want 1", enable_execute);
        end
        start = 1'b1; prog_len = 5'd5;
        load_en = 1'b1; load_addr = 4'd1; load_data = 32'hDEADBEEF;
      end
      if (c == 3) begin
        start = 1'b0; load_en = 1'b0;
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ign_done: done %b busy %b want 1 0", done, busy);
    end
    step();
    pulse_start(5'd3);
    repeat (5) step();
    checks++;
    if (instruction !== Addi) begin
      errors++; $display("FAIL ign_mem: got %h want %h", instruction, Addi);
    end
    repeat (7) step();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL ign_rerun_done: got %b want 1", done);
    end
    step();
  endtask

  task automatic test_full_depth();
    int fetches;
    logic [31:0] exp_idle;
    for (int i = 0; i < 16; i++) write_mem(4'(i), 32'(i));
    pulse_start(5'd16);
    fetches = 0;
    for (int c = 0; c < 64; c++) begin
      if (enable_fetch === 1'b1) fetches++;
      if ((c % 4) == 1) begin
        checks++;
        if (instruction !== 32'((c - 1) / 4)) begin
          errors++; $display("FAIL full_ir c=%0d: got %h want %h", c, instruction, (c - 1) / 4);
        end
      end
      step();
    end
`ifdef IFU_NOP_FILL_EN
    exp_idle = Nop;
`else
    exp_idle = 32'd15;
`endif
    checks++;
    if (fetches != 16) begin
      errors++; $display("FAIL full_fetches: got %0d want 16", fetches);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pc !== 4'd0) begin
      errors++; $display("FAIL full_done: done %b busy %b pc %0d want 1 0 0", done, busy, pc);
    end
    checks++;
    if (instruction !== exp_idle) begin
      errors++; $display("FAIL full_idle_ir: got %h want %h", instruction, exp_idle);
    end
    repeat (4) step();
    checks++;
    if (busy !== 1'b0 || enable_fetch !== 1'b0) begin
      errors++; $display("FAIL full_nowrap: busy %b fetch %b want 0 0", busy, enable_fetch);
    end
  endtask

  task automatic test_reset_midrun();
    logic [4:0] ctl;
    logic [31:0] exp_idle;
    for (int i = 0; i < 3; i++) write_mem(4'(i), basic_prog[i]);
    pulse_start(5'd3);
    repeat (5) step();
    checks++;
    if (instruction !== Addi || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre: ir %h busy %b want %h 1", instruction, busy, Addi);
    end
    #2 reset = 1'b0;
    #1;
    ctl = {enable_fetch, enable_execute, enable_writeback, busy, done};
    checks++;
    if (ctl !== 5'b0 || pc !== 4'd0 || instruction !== Nop) begin
      errors++;
      $display("FAIL mid_reset: ctl %b pc %0d ir %h want 00000 0 %h", ctl, pc, instruction, Nop);
    end
    step();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || instruction !== Nop) begin
      errors++; $display("FAIL mid_stay_idle: busy %b ir %h want 0 %h", busy, instruction, Nop);
    end
    pulse_start(5'd2);
    repeat (8) step();
`ifdef IFU_NOP_FILL_EN
    exp_idle = Nop;
`else
    exp_idle = Addi;
`endif
    checks++;
    if (done !== 1'b1 || instruction !== exp_idle) begin
      errors++;
      $display("FAIL mid_rerun: done %b ir %h want 1 %h", done, instruction, exp_idle);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_busy_ignore();
    test_full_depth();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
